// File: rtl/phoneme_sequencer.sv
// -----------------------------------------------------------------------------
// phoneme_sequencer
//
// Plays one phoneme out of Avalon flash on request from the PicoBlaze. Each
// phoneme occupies a slot of 2^SLOT_SHIFT words; SLOT_WORDS words are read
// one at a time and each 32-bit word is emitted as two 16-bit samples (low
// half first), one per sample_tick. Code 0 plays silence without touching
// flash; codes above MAX_CODE finish immediately with a single done_pulse.
//
// Handshakes:
//   Flash read: mem_read/mem_addr stay asserted and stable in REQ until a
//   cycle with mem_waitrequest=0 accepts the read; the data then arrives on
//   any later cycle with mem_readdatavalid=1 and is only accepted in
//   WAIT_DATA. Audio: audio_valid is a one-cycle qualifier; audio_sample
//   holds its previous value otherwise. Ticks arriving while fetching are
//   dropped, never queued.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   phoneme_code/valid   start strobe and code (honoured only in IDLE)
//   sample_tick          audio sample-rate enable
//   mem_*                Avalon-MM read master towards flash
//   audio_sample/valid   sample output
//   busy                 high from the cycle after start until FINISH->IDLE
//   done_pulse           one cycle, coincident with the return to IDLE
//   fsm_state            current FSM state, for debug/observation
// -----------------------------------------------------------------------------
module phoneme_sequencer #(
  parameter int SLOT_SHIFT = 12,
  parameter int SLOT_WORDS = 4096,
  parameter int MAX_CODE   = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  phoneme_code,
  input  logic        phoneme_valid,
  input  logic        sample_tick,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid,
  output logic        mem_read,
  output logic [22:0] mem_addr,
  output logic [15:0] audio_sample,
  output logic        audio_valid,
  output logic        busy,
  output logic        done_pulse,
  output logic [2:0]  fsm_state
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REQ       = 3'd1;
  localparam logic [2:0] WAIT_DATA = 3'd2;
  localparam logic [2:0] PLAY_LO   = 3'd3;
  localparam logic [2:0] PLAY_HI   = 3'd4;
  localparam logic [2:0] FINISH    = 3'd5;

  // One extra count of headroom so word_idx can represent SLOT_WORDS itself.
  localparam int         IDX_W    = $clog2(SLOT_WORDS + 1);
  localparam logic [7:0] MAX_C    = 8'(MAX_CODE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOT_WORDS - 1);

  logic [2:0]       state;
  logic [7:0]       code;
  logic [IDX_W-1:0] word_idx;
  logic             silence;
  logic [31:0]      word;

  // Address is a pure function of registers that only change outside REQ,
  // so it is stable for as long as mem_read is held.
  assign mem_addr  = (23'(code) << SLOT_SHIFT) + 23'(word_idx);
  assign mem_read  = (state == REQ);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      code         <= 8'd0;
      word_idx     <= '0;
      silence      <= 1'b0;
      word         <= 32'd0;
      audio_sample <= 16'd0;
      audio_valid  <= 1'b0;
      done_pulse   <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      done_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (phoneme_valid) begin
            word_idx <= '0;
            if (phoneme_code == 8'd0) begin
              code    <= 8'd0;
              silence <= 1'b1;
              state   <= PLAY_LO;
            end else if (phoneme_code > MAX_C) begin
              silence <= 1'b0;
              state   <= FINISH;
            end else begin
              code    <= phoneme_code;
              silence <= 1'b0;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (!mem_waitrequest) state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (mem_readdatavalid) begin
            word  <= mem_readdata;
            state <= PLAY_LO;
          end
        end
        PLAY_LO: begin
          if (sample_tick) begin
            audio_sample <= silence ? 16'd0 : word[15:0];
            audio_valid  <= 1'b1;
            state        <= PLAY_HI;
          end
        end
        PLAY_HI: begin
          if (sample_tick) begin
            audio_sample <= silence ? 16'd0 : word[31:16];
            audio_valid  <= 1'b1;
            word_idx     <= word_idx + 1'b1;
            if (word_idx == LAST_IDX) state <= FINISH;
            else if (silence)         state <= PLAY_LO;
            else                      state <= REQ;
          end
        end
        FINISH: begin
          // done_pulse is registered, so it rises on the same edge that
          // returns to IDLE and drops busy.
          done_pulse <= 1'b1;
          silence    <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phoneme_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phoneme_sequencer
//
// Drives phoneme_sequencer (SLOT_WORDS=2) with a table of phoneme requests
// against a small flash model with programmable waitrequest stretch and read
// latency, then runs hand-written sequences for the out-of-range timing and
// reset-during-fetch cases.
// -----------------------------------------------------------------------------
module tb_phoneme_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  phoneme_code = 8'd0;
  logic        phoneme_valid = 1'b0;
  logic        sample_tick = 1'b0;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = 32'd0;
  logic        mem_readdatavalid = 1'b0;
  logic        mem_read;
  logic [22:0] mem_addr;
  logic [15:0] audio_sample;
  logic        audio_valid;
  logic        busy;
  logic        done_pulse;
  logic [2:0]  fsm_state;

  phoneme_sequencer #(.SLOT_SHIFT(12), .SLOT_WORDS(2), .MAX_CODE(63)) dut (
    .clk(clk), .reset(reset),
    .phoneme_code(phoneme_code), .phoneme_valid(phoneme_valid),
    .sample_tick(sample_tick),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid),
    .mem_read(mem_read), .mem_addr(mem_addr),
    .audio_sample(audio_sample), .audio_valid(audio_valid),
    .busy(busy), .done_pulse(done_pulse), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- sample tick: one every 6 cycles ----------------
  int tick_cnt = 0;
  always @(negedge clk) begin
    tick_cnt++;
    sample_tick = (tick_cnt % 6 == 0);
  end

  // ---------------- flash model ----------------
  int          wait_n = 0;   // waitrequest cycles before each accept
  int          lat = 2;      // negedges from accept to readdatavalid
  int          wr_cnt = 0;
  int          rdv_cnt = 0;
  logic [31:0] pend_data = 32'd0;
  logic [22:0] obs_a[$];     // accepted read addresses

  function automatic logic [31:0] flash_word(input logic [22:0] a);
    if (a == 23'h5000) return 32'h1111_2222;
    if (a == 23'h5001) return 32'h3333_4444;
    return {~a[15:0], a[15:0]};
  endfunction

  always @(negedge clk) begin
    mem_readdatavalid = 1'b0;
    if (rdv_cnt > 0) begin
      rdv_cnt--;
      if (rdv_cnt == 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata = pend_data;
      end
    end
    if (mem_read) begin
      if (wr_cnt < wait_n) begin
        mem_waitrequest = 1'b1;
        wr_cnt++;
      end else begin
        mem_waitrequest = 1'b0;
        wr_cnt = 0;
        rdv_cnt = lat;
        pend_data = flash_word(mem_addr);
        obs_a.push_back(mem_addr);
      end
    end else begin
      mem_waitrequest = 1'b0;
    end
  end

  // ---------------- output monitor ----------------
  logic [15:0] obs_s[$];
  int          done_cnt = 0;
  int          read_cyc = 0;
  int          stab_err = 0;
  logic        prev_rd = 1'b0;
  logic [22:0] prev_addr = 23'd0;

  always @(negedge clk) begin
    if (audio_valid) obs_s.push_back(audio_sample);
    if (done_pulse) done_cnt++;
    if (mem_read) begin
      read_cyc++;
      if (prev_rd && mem_addr != prev_addr) stab_err++;
    end
    prev_rd = mem_read;
    prev_addr = mem_addr;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  code;
    int          wait_n;
    bit          inject;      // strobe code 7 mid-phoneme
    int          n_reads;
    logic [22:0] addr0;
    int          n_samples;
    logic [15:0] s[4];
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx, input vec_t v);
    int b_s, b_a, b_d, b_r, b_st, t, ns, na;
    b_s = obs_s.size(); b_a = obs_a.size(); b_d = done_cnt;
    b_r = read_cyc; b_st = stab_err;
    wait_n = v.wait_n; lat = 2;
    @(negedge clk); phoneme_code = v.code; phoneme_valid = 1'b1;
    @(negedge clk); phoneme_valid = 1'b0;
    if (v.inject) begin
      repeat (4) @(negedge clk);
      phoneme_code = 8'd7; phoneme_valid = 1'b1;
      @(negedge clk); phoneme_valid = 1'b0;
    end
    t = 0;
    while (done_cnt == b_d && t < 3000) begin
      @(negedge clk); t++;
    end
    chk($sformatf("v%0d_timeout", idx), 32'(t < 3000), 32'd1);
    repeat (3) @(negedge clk);
    ns = obs_s.size() - b_s;
    na = obs_a.size() - b_a;
    chk($sformatf("v%0d_done_cnt", idx), 32'(done_cnt - b_d), 32'd1);
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d_n_reads", idx), 32'(na), 32'(v.n_reads));
    chk($sformatf("v%0d_read_cycles", idx), 32'(read_cyc - b_r), 32'(v.n_reads * (v.wait_n + 1)));
    chk($sformatf("v%0d_addr_stable", idx), 32'(stab_err - b_st), 32'd0);
    if (na == v.n_reads)
      for (int i = 0; i < na; i++)
        chk($sformatf("v%0d_addr%0d", idx, i), 32'(obs_a[b_a + i]), 32'(v.addr0 + 23'(i)));
    chk($sformatf("v%0d_n_samples", idx), 32'(ns), 32'(v.n_samples));
    if (ns == v.n_samples) begin
      for (int i = 0; i < ns; i++)
        chk($sformatf("v%0d_sample%0d", idx, i), 32'(obs_s[b_s + i]), 32'(v.s[i]));
      if (ns > 0)
        chk($sformatf("v%0d_sample_hold", idx), 32'(audio_sample), 32'(v.s[ns - 1]));
    end
  endtask

  initial begin
    int b_d, b_s, b_r, t;
    vecs[0] = '{8'd5,   0, 1'b0, 2, 23'h05000, 4, '{16'h2222, 16'h1111, 16'h4444, 16'h3333}};
    vecs[1] = '{8'd5,   3, 1'b0, 2, 23'h05000, 4, '{16'h2222, 16'h1111, 16'h4444, 16'h3333}};
    vecs[2] = '{8'd0,   0, 1'b0, 0, 23'h00000, 4, '{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    vecs[3] = '{8'd9,   1, 1'b0, 2, 23'h09000, 4, '{16'h9000, 16'h6FFF, 16'h9001, 16'h6FFE}};
    vecs[4] = '{8'd5,   2, 1'b1, 2, 23'h05000, 4, '{16'h2222, 16'h1111, 16'h4444, 16'h3333}};
    vecs[5] = '{8'd63,  0, 1'b0, 2, 23'h3F000, 4, '{16'hF000, 16'h0FFF, 16'hF001, 16'h0FFE}};
    vecs[6] = '{8'd200, 0, 1'b0, 0, 23'h00000, 0, '{16'h0000, 16'h0000, 16'h0000, 16'h0000}};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_audio_sample", 32'(audio_sample), 32'd0);
    chk("rst_audio_valid", 32'(audio_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_pulse), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Out-of-range code: done_pulse two edges after the strobe, nothing else
    b_s = obs_s.size(); b_r = read_cyc;
    @(negedge clk); phoneme_code = 8'd64; phoneme_valid = 1'b1;
    @(negedge clk); phoneme_valid = 1'b0;
    chk("oor_done_edge1", 32'(done_pulse), 32'd0);
    chk("oor_busy_edge1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("oor_done_edge2", 32'(done_pulse), 32'd1);
    chk("oor_busy_edge2", 32'(busy), 32'd0);
    @(negedge clk);
    chk("oor_done_one_cycle", 32'(done_pulse), 32'd0);
    chk("oor_no_audio", 32'(obs_s.size() - b_s), 32'd0);
    chk("oor_no_read", 32'(read_cyc - b_r), 32'd0);

    // Reset while waiting for data, then a late readdatavalid arrives
    wait_n = 0; lat = 4;
    @(negedge clk); phoneme_code = 8'd9; phoneme_valid = 1'b1;
    @(negedge clk); phoneme_valid = 1'b0;
    t = 0;
    while (fsm_state != 3'd2 && t < 200) begin
      @(negedge clk); t++;
    end
    chk("rstwait_reached", 32'(t < 200), 32'd1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    b_d = done_cnt; b_s = obs_s.size(); b_r = read_cyc;
    repeat (10) @(negedge clk);
    chk("rstwait_state", 32'(fsm_state), 32'd0);
    chk("rstwait_busy", 32'(busy), 32'd0);
    chk("rstwait_no_done", 32'(done_cnt - b_d), 32'd0);
    chk("rstwait_no_audio", 32'(obs_s.size() - b_s), 32'd0);
    chk("rstwait_no_read", 32'(read_cyc - b_r), 32'd0);
    lat = 2;

    // Sequencer still usable after the abort
    run_vec(7, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
